// File: rtl/node_walker.sv
// Graph neighbour walker: a flop-based adjacency table with a write port and a
// streaming traversal that emits a node's valid neighbours in ascending slot order.
module node_walker #(
    parameter int NODES = 26,
    parameter int DEG   = 4,
    parameter int IW    = 5,
    parameter int WW    = 2,
    parameter int NONE  = 30,
    parameter int SW    = $clog2(DEG),
    localparam int EW   = WW + IW,
    localparam int CW   = $clog2(DEG + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_node,
    input  logic [SW-1:0] wr_slot,
    input  logic [EW-1:0] wr_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [IW-1:0] req_node,
    output logic          nb_valid,
    input  logic          nb_ready,
    output logic [IW-1:0] nb_id,
    output logic [WW-1:0] nb_weight,
    output logic [SW-1:0] nb_slot,
    output logic          nb_last,
    output logic [CW-1:0] nb_count,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t        state_reg, state_next;
    logic [EW-1:0] tbl_reg  [NODES][DEG];
    logic [EW-1:0] snap_reg [DEG];
    logic [SW-1:0] slot_reg, slot_next;
    logic [CW-1:0] count_reg;
    logic          err_reg;

    logic          wr_ok, wr_node_ok, wr_slot_ok;
    logic          req_fire, req_ok, load_snap;
    logic [IW-1:0] row_sel;
    logic [DEG-1:0] row_valid, snap_valid;
    logic [SW-1:0] row_first, above_next;
    logic          row_any, has_above;
    logic [CW-1:0] row_cnt;

    function automatic logic ent_valid(input logic [IW-1:0] id);
        return (id != IW'(NONE)) && ({1'b0, id} < (IW+1)'(NODES));
    endfunction

    assign wr_node_ok = {1'b0, wr_node} < (IW+1)'(NODES);
    generate
        if (DEG == (1 << SW)) begin : g_slot_full
            assign wr_slot_ok = 1'b1;
        end else begin : g_slot_part
            assign wr_slot_ok = 32'(wr_slot) < DEG;
        end
    endgenerate
    assign wr_ok    = wr_node_ok & wr_slot_ok;
    assign req_fire = req_valid & (state_reg == IDLE);
    assign req_ok   = {1'b0, req_node} < (IW+1)'(NODES);
    assign row_sel  = req_ok ? req_node : '0;

    genvar gi;
    generate
        for (gi = 0; gi < DEG; gi++) begin : g_valid
            assign row_valid[gi]  = ent_valid(tbl_reg[row_sel][gi][IW-1:0]);
            assign snap_valid[gi] = ent_valid(snap_reg[gi][IW-1:0]);
        end
    endgenerate

    // Priority scans: lowest valid slot of the requested row, and the lowest
    // valid snapshot slot strictly above the one currently presented.
    always_comb begin
        row_first  = '0;
        row_any    = 1'b0;
        row_cnt    = '0;
        above_next = '0;
        has_above  = 1'b0;
        for (int s = DEG - 1; s >= 0; s--) begin
            if (row_valid[s]) begin
                row_first = SW'(s);
                row_any   = 1'b1;
            end
            if (snap_valid[s] && (s > int'(slot_reg))) begin
                above_next = SW'(s);
                has_above  = 1'b1;
            end
            row_cnt = row_cnt + CW'(row_valid[s]);
        end
    end

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        load_snap  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_fire && req_ok) begin
                    load_snap = 1'b1;
                    if (row_any) begin
                        state_next = EMIT;
                        slot_next  = row_first;
                    end else begin
                        state_next = DONE;
                        slot_next  = '0;
                    end
                end
            end
            EMIT: begin
                if (nb_ready) begin
                    if (has_above) begin
                        slot_next = above_next;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Snapshot reads the pre-edge table, so a same-cycle write never leaks in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NODES; n++) begin
                for (int s = 0; s < DEG; s++) begin
                    tbl_reg[n][s] <= {{WW{1'b1}}, IW'(NONE)};
                end
            end
            for (int s = 0; s < DEG; s++) begin
                snap_reg[s] <= '0;
            end
            slot_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (wr_en && wr_ok) begin
                tbl_reg[wr_node][wr_slot] <= wr_data;
            end
            if (load_snap) begin
                for (int s = 0; s < DEG; s++) begin
                    snap_reg[s] <= tbl_reg[row_sel][s];
                end
                count_reg <= row_cnt;
            end
            slot_reg <= slot_next;
            err_reg  <= (wr_en & ~wr_ok) | (req_fire & ~req_ok);
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign nb_valid  = (state_reg == EMIT);
    assign nb_id     = snap_reg[slot_reg][IW-1:0];
    assign nb_weight = snap_reg[slot_reg][EW-1:IW];
    assign nb_slot   = slot_reg;
    assign nb_last   = nb_valid & ~has_above;
    assign nb_count  = count_reg;
    assign done      = (state_reg == DONE);
    assign err       = err_reg;
endmodule

// File: doc/node_walker.md
NODE_WALKER -- requirements
Module: node_walker

Interface
REQ-001 Parameter NODES, 26, number of graph nodes.
REQ-002 Parameter DEG, 4, neighbour slots per node.
REQ-003 Parameter IW, 5, node-id width.
REQ-004 Parameter WW, 2, edge-weight width.
REQ-005 Parameter NONE, 30, reserved id marking an empty slot.
REQ-006 Parameter SW, clog2(DEG), slot-index width; entry width EW = WW+IW, layout {weight, id}, weight in MSBs.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 wr_en  in  1  table write strobe.
REQ-010 wr_node  in  IW  node to write.
REQ-011 wr_slot  in  SW  slot to write.
REQ-012 wr_data  in  EW  entry {weight, id}.
REQ-013 req_valid  in  1  traversal request.
REQ-014 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-015 req_node  in  IW  node whose neighbours are streamed.
REQ-016 nb_valid  out  1  neighbour beat valid.
REQ-017 nb_ready  in  1  consumer accepts beat.
REQ-018 nb_id, nb_weight, nb_slot  out  IW, WW, SW  neighbour id, edge weight, source slot.
REQ-019 nb_last  out  1  final valid neighbour of this traversal.
REQ-020 nb_count  out  clog2(DEG+1)  valid-neighbour count of the node, stable for the whole traversal.
REQ-021 done  out  1  one-cycle traversal-complete pulse.
REQ-022 err  out  1  one-cycle pulse on an out-of-range write or request.

Function
REQ-023 Table SHALL hold NODES x DEG entries in flops; a slot is valid iff id != NONE and id < NODES.
REQ-024 wr_en with wr_node < NODES and wr_slot < DEG SHALL update the entry at the clock edge; otherwise the write SHALL be dropped and err SHALL pulse the next cycle.
REQ-025 FSM states: IDLE, EMIT, DONE; req_ready = 1 only in IDLE.
REQ-026 On request accept in cycle T with req_node >= NODES: err pulses at T+1, FSM stays IDLE, no beats, no done.
REQ-027 On valid accept at T: the node's DEG entries SHALL be snapshotted with pre-write values (a same-cycle write is excluded); later writes SHALL NOT affect the current traversal.
REQ-028 Snapshot with >= 1 valid slot: EMIT from T+1, nb_valid = 1 and the lowest valid slot presented; nb_count SHALL be valid from T+1.
REQ-029 Snapshot with no valid slot: DONE at T+1 (done = 1, nb_valid = 0, nb_count = 0), IDLE at T+2.
REQ-030 In EMIT, while nb_ready = 0, all nb_* outputs SHALL hold stable.
REQ-031 On nb_valid & nb_ready, the next beat SHALL present the next higher valid slot in the following cycle, skipping invalid slots with zero bubble cycles.
REQ-032 nb_last = 1 iff no valid slot lies above the current slot; its handshake SHALL move the FSM to DONE (done = 1 one cycle, nb_valid = 0), then IDLE.
REQ-033 Beats SHALL be emitted in ascending slot order, one per handshake; throughput 1 beat/cycle with nb_ready held high.
REQ-034 err from a bad write and a bad request in the same cycle SHALL produce a single one-cycle pulse.
REQ-035 A write in EMIT or DONE SHALL be accepted normally.

Reset
REQ-036 rst SHALL asynchronously force: FSM IDLE, nb_valid/done/err = 0, nb_last = 0, nb_id/nb_weight/nb_slot/nb_count = 0, all table entries = {all-ones weight, NONE}, snapshot cleared.
REQ-037 rst during EMIT SHALL abort the traversal with no done pulse; req_ready = 1 on the first edge after release.

Verification
REQ-038 Write node 2 = {3,1},{1,3},{3,5},{3,30}; request 2, nb_ready = 1 -> beats (1,w3,s0), (3,w1,s1), (5,w3,s2,last), nb_count = 3, done on the cycle after beat 3.
REQ-039 Node 12 slots = {3,30},{2,7},{3,29},{3,17}; request -> beats id7 slot1, id17 slot3 last (id 29 >= NODES skipped), back-to-back cycles, count = 2.
REQ-040 nb_ready low 3 cycles during beat 2 of REQ-038 -> nb_id = 3, nb_weight = 1, nb_slot = 1 held, no beat lost or duplicated.
REQ-041 Request node 4 after reset -> no nb_valid, done at T+1, req_ready = 0 at T+1 and 1 at T+2; request node 26 -> err at T+1, no done; write node 27 -> err, table unchanged.
REQ-042 During a node 12 traversal, write slot 3 = {3,30} -> id17 still emitted; re-request -> only id7 with last = 1.
REQ-043 Assert rst mid-EMIT -> nb_valid = 0 immediately; request node 2 after release -> done at T+1, zero beats.
